// File: rtl/uart_pkg.sv
// uart_pkg: shared UART timing constants and the tx-fifo launch FSM state type
package uart_pkg;
  typedef enum logic {IDLE, WAIT_DONE} tx_fifo_state_t;
  localparam int UART_CLK_FREQ = 50_000_000;
  localparam int UART_BAUD = 115200;
  localparam int UART_BIT_CLKS = UART_CLK_FREQ / UART_BAUD;
endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// sync_fifo: single-clock FIFO whose occupancy count arbitrates full/empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign push = wr_en && !full;
  assign pop = rd_en && !empty;
  assign full = count == (ADDR_W+1)'(DEPTH);
  assign empty = count == '0;
  assign rd_data = mem[rd_ptr];
  // storage array, written only on an accepted push
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
  // pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + ADDR_W'(push);
      rd_ptr <= rd_ptr + ADDR_W'(pop);
      count <= count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte queue that launches one byte at a time into UART_Tx; UART_TX_FIFO_STATS_EN adds drop statistics
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_wr_valid,
  input  logic [7:0]      i_wr_data,
  output logic            o_wr_ready,
  output logic            o_TX_DV,
  output logic [7:0]      o_TX_Byte,
  input  logic            i_TX_Active,
  input  logic            i_TX_Done,
  output logic [ADDR_W:0] o_count,
  output logic            o_empty,
  output logic            o_full,
  output logic            o_busy
`ifdef UART_TX_FIFO_STATS_EN
  ,
  output logic            o_overflow,
  output logic [7:0]      o_drop_cnt
`endif
);
  tx_fifo_state_t state, state_nx;
  logic launch;
  logic [7:0] head;
  logic unused_tx_active;
  assign unused_tx_active = i_TX_Active;
  assign o_wr_ready = !o_full;
  assign o_busy = state != IDLE;
  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(i_wr_valid),
    .wr_data(i_wr_data),
    .rd_en(launch),
    .rd_data(head),
    .count(o_count),
    .full(o_full),
    .empty(o_empty)
  );
  // launch the head byte whenever idle with data queued; Done outside WAIT_DONE is ignored
  always_comb begin
    launch = 1'b0;
    state_nx = state;
    launch = state == IDLE && !o_empty;
    state_nx = state == IDLE ? (o_empty ? IDLE : WAIT_DONE) : (i_TX_Done ? IDLE : WAIT_DONE);
  end
  // state register, one-cycle strobe and held launch byte
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      o_TX_DV <= 1'b0;
      o_TX_Byte <= '0;
    end else begin
      state <= state_nx;
      o_TX_DV <= launch;
      o_TX_Byte <= launch ? head : o_TX_Byte;
    end
`ifdef UART_TX_FIFO_STATS_EN
  logic drop;
  assign drop = i_wr_valid && o_full;
  // sticky overflow flag and saturating drop counter
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      o_overflow <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      o_overflow <= o_overflow | drop;
      o_drop_cnt <= o_drop_cnt + 8'(drop && o_drop_cnt != 8'hFF);
    end
`endif
endmodule
